wand_bus_tx: RTL

Bit-serial transmitter for a shared open-drain (wired-AND, pulled-up) single-line bus. It accepts a byte over a valid/ready handshake, waits for the line to be idle, and frames the byte onto the bus by pulling low or releasing. It reads back the resolved line every bit and aborts on arbitration loss or bus fault. It is the driving end that pairs with the team's net-resolution models: the line itself is a `tri1`/`wand` net outside this block, and this block only controls the pull-down enable.

---
 rtl/wand_bus_pkg.sv | 23 ++
 rtl/wand_bit_timer.sv | 43 ++++
 rtl/wand_bus_tx.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/wand_bus_pkg.sv
// Shared types and constants for the wired-AND bus transmitter and its timer.
// Optional feature macro: WAND_TX_PARITY_EN (adds the PARITY state).
package wand_bus_pkg;

  localparam int DEFAULT_BIT_CYCLES = 4;
  localparam int DEFAULT_DATA_W     = 8;

  // Resolved line levels on the open-drain bus.
  localparam logic BUS_DOMINANT  = 1'b0;
  localparam logic BUS_RECESSIVE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_FREE = 3'd1,
    ST_START     = 3'd2,
    ST_DATA      = 3'd3,
`ifdef WAND_TX_PARITY_EN
    ST_PARITY    = 3'd4,
`endif
    ST_STOP      = 3'd5
  } wand_tx_state_t;

endpackage

// File: rtl/wand_bit_timer.sv
// Bit-period counter. While start is high it counts 0..BIT_CYCLES-1 and wraps;
// clear forces it back to 0 and wins over start. sample marks the last cycle
// of a period (counter at BIT_CYCLES-1 while counting).
module wand_bit_timer
  import wand_bus_pkg::*;
#(
  parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES,
  parameter int CNT_W      = $clog2(BIT_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic sample
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             last;

  assign last   = (cnt_q == CNT_W'(BIT_CYCLES - 1));
  assign sample = start && !clear && last;

  // Next count: clear, wrap at the end of the period, or advance.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (start) begin
      cnt_d = last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wand_bus_tx.sv
// Bit-serial transmitter for an open-drain wired-AND bus. Waits for the line
// to stay released for a full bit period, frames start/data(MSB first)/stop,
// and reads the line back at the end of every bit to detect arbitration loss
// or a stuck-high fault. Optional macro: WAND_TX_PARITY_EN adds an even
// parity bit between data and stop.
//
// Handshake: a frame is accepted on a clock edge where tx_valid and tx_ready
// are both high; tx_data is sampled only on that edge, and tx_ready stays low
// from the next cycle until the frame completes or aborts.
module wand_bus_tx
  import wand_bus_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  input  logic              bus_in,
  output logic              bus_oe,
  output logic              busy,
  output logic              done,
  output logic              arb_lost,
  output logic              fault,
  output logic [2:0]        dbg_state
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  wand_tx_state_t    state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              bus_oe_q, bus_oe_d;
  logic              tx_ready_q, tx_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              arb_lost_q, arb_lost_d;
  logic              fault_q, fault_d;

  logic              timer_run;
  logic              timer_clear;
  logic              sample;
  logic              intended_lvl;

  // The timer idles at 0 in IDLE; in WAIT_FREE any low sample restarts the
  // idle-line count, so sample there means BIT_CYCLES consecutive highs.
  assign timer_run   = (state_q != ST_IDLE);
  assign timer_clear = (state_q == ST_IDLE) ||
                       ((state_q == ST_WAIT_FREE) && (bus_in == BUS_DOMINANT));

  wand_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (timer_run),
    .clear  (timer_clear),
    .sample (sample)
  );

  // Level this block expects on the line for the bit currently driven.
  assign intended_lvl = bus_oe_q ? BUS_DOMINANT : BUS_RECESSIVE;

  // Next-state and registered-output logic; bus_oe only changes on sample.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    bus_oe_d   = bus_oe_q;
    done_d     = 1'b0;
    arb_lost_d = 1'b0;
    fault_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tx_valid && tx_ready_q) begin
          shift_d = tx_data;
          state_d = ST_WAIT_FREE;
        end
      end
      ST_WAIT_FREE: begin
        if (sample && (bus_in == BUS_RECESSIVE)) begin
          bus_oe_d = 1'b1;
          state_d  = ST_START;
        end
      end
      default: begin
        if (sample) begin
          if (bus_in != intended_lvl) begin
            bus_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = ST_IDLE;
            if (intended_lvl == BUS_RECESSIVE) begin
              arb_lost_d = 1'b1;
            end else begin
              fault_d = 1'b1;
            end
          end else begin
            case (state_q)
              ST_START: begin
                bus_oe_d = ~shift_q[DATA_W-1];
                state_d  = ST_DATA;
              end
              ST_DATA: begin
                // Rotate so the payload is intact again for the parity XOR.
                shift_d = {shift_q[DATA_W-2:0], shift_q[DATA_W-1]};
                if (bit_cnt_q == BW'(DATA_W - 1)) begin
                  bit_cnt_d = '0;
`ifdef WAND_TX_PARITY_EN
                  bus_oe_d  = ~(^shift_q);
                  state_d   = ST_PARITY;
`else
                  bus_oe_d  = 1'b0;
                  state_d   = ST_STOP;
`endif
                end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
                  bus_oe_d  = ~shift_q[DATA_W-2];
                end
              end
`ifdef WAND_TX_PARITY_EN
              ST_PARITY: begin
                bus_oe_d = 1'b0;
                state_d  = ST_STOP;
              end
`endif
              ST_STOP: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end
              default: begin
                bus_oe_d = 1'b0;
                state_d  = ST_IDLE;
              end
            endcase
          end
        end
      end
    endcase

    tx_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  // State and output registers; reset releases the line immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      bus_oe_q   <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      arb_lost_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      bus_oe_q   <= bus_oe_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      arb_lost_q <= arb_lost_d;
      fault_q    <= fault_d;
    end
  end

  assign tx_ready  = tx_ready_q;
  assign bus_oe    = bus_oe_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign arb_lost  = arb_lost_q;
  assign fault     = fault_q;
  assign dbg_state = state_q;

endmodule
